// File: rtl/raster_pkg.sv
// -----------------------------------------------------------------------------
// raster_pkg
// Shared definitions for the raster scan controller:
//   - default counter widths for column, row and pass
//   - FSM state encoding (IDLE, SCAN, DONE)
// Optional feature macro used by the controller: RASTER_SCAN_HALO_EN
// -----------------------------------------------------------------------------
package raster_pkg;

    localparam int DEF_COL_W  = 10;
    localparam int DEF_ROW_W  = 9;
    localparam int DEF_PASS_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Up-counter that wraps to zero after reaching a runtime maximum.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance by one (wraps to 0 when value == max)
//   clr        : synchronous clear, wins over inc
//   max        : last value before wrapping (full W-bit compare)
//   value      : current count (registered)
//   at_max     : value == max
// -----------------------------------------------------------------------------
module wrap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] max,
    output logic [W-1:0] value,
    output logic         at_max
);

    logic [W-1:0] value_r;

    assign value  = value_r;
    // Full-width equality: a max of 2^W-1 never needs value+1 to compare.
    assign at_max = (value_r == max);

    // Count register: clear has priority, increment wraps after max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= {W{1'b0}};
        end else if (clr) begin
            value_r <= {W{1'b0}};
        end else if (inc) begin
            value_r <= at_max ? {W{1'b0}} : (value_r + W'(1'b1));
        end else begin
            value_r <= value_r;
        end
    end

endmodule

// File: rtl/raster_scan_ctl.sv
// -----------------------------------------------------------------------------
// raster_scan_ctl
// Generates a col/row/pass coordinate stream (col innermost) with a
// valid/ready handshake. Geometry is latched when a start is accepted in IDLE.
// Optional macro RASTER_SCAN_HALO_EN: extends col and row by a one-pixel
// border on each side and adds the 'halo' output flagging border coordinates.
// In that build cfg_cols/cfg_rows must leave room for +1 in their width.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start, abort            : scan request (IDLE only) / synchronous cancel
//   cfg_cols/rows/passes    : frame geometry
//   out_ready               : downstream accepts the current coordinate
//   col, row, pass          : current coordinate
//   out_valid               : coordinate valid (SCAN state)
//   row_last, frame_last    : last column of a row / last coordinate of scan
//   done                    : one-cycle completion pulse
//   busy                    : SCAN or DONE
//   halo (macro only)       : current coordinate lies on the border
// -----------------------------------------------------------------------------
module raster_scan_ctl
    import raster_pkg::*;
#(
    parameter int COL_W  = DEF_COL_W,
    parameter int ROW_W  = DEF_ROW_W,
    parameter int PASS_W = DEF_PASS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [COL_W-1:0]  cfg_cols,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [PASS_W-1:0] cfg_passes,
    input  logic              out_ready,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [PASS_W-1:0] pass,
    output logic              out_valid,
    output logic              row_last,
    output logic              frame_last,
    output logic              done,
    output logic              busy
`ifdef RASTER_SCAN_HALO_EN
    ,
    output logic              halo
`endif
);

    state_t              state_r;
    state_t              state_s;
    logic [COL_W-1:0]    cfg_cols_r;
    logic [ROW_W-1:0]    cfg_rows_r;
    logic [PASS_W-1:0]   cfg_passes_r;

    logic                scan_s;
    logic                start_ok_s;
    logic                cfg_zero_s;
    logic                beat_s;
    logic                cnt_clr_s;
    logic                row_inc_s;
    logic                pass_inc_s;
    logic [COL_W-1:0]    col_max_s;
    logic [ROW_W-1:0]    row_max_s;
    logic [PASS_W-1:0]   pass_max_s;
    logic                col_at_max_s;
    logic                row_at_max_s;
    logic                pass_at_max_s;

    assign scan_s     = (state_r == ST_SCAN);
    assign start_ok_s = (state_r == ST_IDLE) & start & ~abort;
    assign cfg_zero_s = (cfg_cols == {COL_W{1'b0}}) | (cfg_rows == {ROW_W{1'b0}})
                      | (cfg_passes == {PASS_W{1'b0}});
    // A beat is a handshake that is not overridden by abort.
    assign beat_s     = scan_s & out_ready & ~abort;
    assign row_inc_s  = beat_s & col_at_max_s;
    assign pass_inc_s = row_inc_s & row_at_max_s;
    // Counters sit at zero outside SCAN, so a fresh scan always starts at (0,0,0).
    assign cnt_clr_s  = abort | ~scan_s | (beat_s & frame_last);

`ifdef RASTER_SCAN_HALO_EN
    // Border adds one column/row on each side: last index is cfg+1.
    assign col_max_s  = cfg_cols_r + COL_W'(1'b1);
    assign row_max_s  = cfg_rows_r + ROW_W'(1'b1);
`else
    // Latched geometry is never zero in SCAN, so cfg-1 cannot underflow there.
    assign col_max_s  = cfg_cols_r - COL_W'(1'b1);
    assign row_max_s  = cfg_rows_r - ROW_W'(1'b1);
`endif
    assign pass_max_s = cfg_passes_r - PASS_W'(1'b1);

    // Geometry capture on an accepted start; later cfg changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_cols_r   <= {COL_W{1'b0}};
            cfg_rows_r   <= {ROW_W{1'b0}};
            cfg_passes_r <= {PASS_W{1'b0}};
        end else if (start_ok_s) begin
            cfg_cols_r   <= cfg_cols;
            cfg_rows_r   <= cfg_rows;
            cfg_passes_r <= cfg_passes;
        end else begin
            cfg_cols_r   <= cfg_cols_r;
            cfg_rows_r   <= cfg_rows_r;
            cfg_passes_r <= cfg_passes_r;
        end
    end

    wrap_counter #(.W(COL_W)) u_col (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (beat_s),
        .clr    (cnt_clr_s),
        .max    (col_max_s),
        .value  (col),
        .at_max (col_at_max_s)
    );

    wrap_counter #(.W(ROW_W)) u_row (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (row_inc_s),
        .clr    (cnt_clr_s),
        .max    (row_max_s),
        .value  (row),
        .at_max (row_at_max_s)
    );

    wrap_counter #(.W(PASS_W)) u_pass (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (pass_inc_s),
        .clr    (cnt_clr_s),
        .max    (pass_max_s),
        .value  (pass),
        .at_max (pass_at_max_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; abort overrides every other transition.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = cfg_zero_s ? ST_DONE : ST_SCAN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (beat_s && frame_last) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SCAN;
                    end
                end
                ST_DONE: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // FSM output decode from the registered state and counters.
    always_comb begin
        out_valid  = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        case (state_r)
            ST_SCAN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            ST_DONE: begin
                done      = 1'b1;
                busy      = 1'b1;
            end
            ST_IDLE: begin
                out_valid = 1'b0;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
        row_last   = scan_s & col_at_max_s;
        frame_last = row_last & row_at_max_s & pass_at_max_s;
    end

`ifdef RASTER_SCAN_HALO_EN
    // Border flag: first/last column or first/last row of the extended frame.
    always_comb begin
        halo = scan_s & ((col == {COL_W{1'b0}}) | col_at_max_s
                       | (row == {ROW_W{1'b0}}) | row_at_max_s);
    end
`endif

endmodule

// File: tb/tb_raster_scan_ctl.sv
// -----------------------------------------------------------------------------
// tb_raster_scan_ctl
// Self-checking bench for raster_scan_ctl. The reference model expands the
// requested geometry into the full ordered list of coordinates and compares
// the DUT against the head of that list every valid cycle.
// -----------------------------------------------------------------------------
module tb_raster_scan_ctl;

    localparam int COL_W  = 10;
    localparam int ROW_W  = 9;
    localparam int PASS_W = 7;
`ifdef RASTER_SCAN_HALO_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif

    typedef struct {
        int c;
        int r;
        int p;
    } coord_t;

    typedef struct {
        int c;
        int r;
        int p;
        int mode;       // 0: ready always, 1: random ready, 2: ready low on valid cycles 2-5
        int exp_beats;
        int exp_valid;  // -1: not checked
        int exp_rl;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [COL_W-1:0]  cfg_cols = '0;
    logic [ROW_W-1:0]  cfg_rows = '0;
    logic [PASS_W-1:0] cfg_passes = '0;
    logic              out_ready = 1'b0;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [PASS_W-1:0] pass;
    logic              out_valid;
    logic              row_last;
    logic              frame_last;
    logic              done;
    logic              busy;
`ifdef RASTER_SCAN_HALO_EN
    logic              halo;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    raster_scan_ctl #(.COL_W(COL_W), .ROW_W(ROW_W), .PASS_W(PASS_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_cols   (cfg_cols),
        .cfg_rows   (cfg_rows),
        .cfg_passes (cfg_passes),
        .out_ready  (out_ready),
        .col        (col),
        .row        (row),
        .pass       (pass),
        .out_valid  (out_valid),
        .row_last   (row_last),
        .frame_last (frame_last),
        .done       (done),
        .busy       (busy)
`ifdef RASTER_SCAN_HALO_EN
        ,
        .halo       (halo)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({col, row, pass, out_valid, row_last, frame_last, done, busy});
    endfunction

    // Start one scan and follow it to completion against the expanded coordinate list.
    task automatic run_scan(input int c, input int r, input int p, input int mode,
                            output int nbeats, output int nvalid, output int nrl);
        coord_t q[$];
        int cw;
        int rw;
        int cyc;
        bit fin;
        cw = c + 2 * HB;
        rw = r + 2 * HB;
        q = {};
        if (c > 0 && r > 0 && p > 0) begin
            for (int pp = 0; pp < p; pp++)
                for (int rr = 0; rr < rw; rr++)
                    for (int cc = 0; cc < cw; cc++)
                        q.push_back('{cc, rr, pp});
        end
        nbeats = 0;
        nvalid = 0;
        nrl    = 0;
        @(posedge clk); #1;
        cfg_cols   = COL_W'(c);
        cfg_rows   = ROW_W'(r);
        cfg_passes = PASS_W'(p);
        start      = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        // Geometry changes after acceptance must not matter.
        cfg_cols   = COL_W'($urandom);
        cfg_rows   = ROW_W'($urandom);
        cfg_passes = PASS_W'($urandom);
        fin = 1'b0;
        cyc = 0;
        while (!fin && cyc < 20000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (nvalid >= 1 && nvalid <= 4) ? 1'b0 : 1'b1;
            endcase
            start = (mode == 1) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            if (out_valid) begin
                nvalid++;
                check("busy_scan", 32'(busy), 32'd1);
                check("done_in_scan", 32'(done), 32'd0);
                if (q.size() == 0) begin
                    check("extra_beat", 32'(q.size()), 32'd1);
                    fin = 1'b1;
                end else begin
                    check("col", 32'(col), 32'(q[0].c));
                    check("row", 32'(row), 32'(q[0].r));
                    check("pass", 32'(pass), 32'(q[0].p));
                    check("row_last", 32'(row_last), 32'(q[0].c == cw - 1));
                    check("frame_last", 32'(frame_last), 32'(q.size() == 1));
`ifdef RASTER_SCAN_HALO_EN
                    check("halo", 32'(halo), 32'(q[0].c == 0 || q[0].c == cw - 1 ||
                                                 q[0].r == 0 || q[0].r == rw - 1));
`endif
                    if (out_ready) begin
                        if (row_last) nrl++;
                        void'(q.pop_front());
                        nbeats++;
                    end
                end
            end else begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_done", 32'(busy), 32'd1);
                check("beats_left", 32'(q.size()), 32'd0);
                fin = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("scan_finished", 32'(fin), 32'd1);
        start = 1'b0;
        @(negedge clk);
        check("idle_after_done", all_outs(), 32'd0);
    endtask

    vec_t tbl[9];

    initial begin
        int nb;
        int nv;
        int nr;
        int cyc;
        int c;
        int r;
        int p;

        tbl[0] = '{4, 3, 2, 0, HB ? 60 : 24, HB ? 60 : 24, HB ? 10 : 6};
        tbl[1] = '{4, 3, 1, 2, HB ? 30 : 12, HB ? 34 : 16, HB ? 5 : 3};
        tbl[2] = '{1, 1, 1, 0, HB ? 9 : 1, HB ? 9 : 1, HB ? 3 : 1};
        tbl[3] = '{0, 3, 2, 0, 0, 0, 0};
        tbl[4] = '{4, 0, 1, 0, 0, 0, 0};
        tbl[5] = '{3, 2, 0, 1, 0, 0, 0};
        tbl[6] = '{2, 2, 1, 0, HB ? 16 : 4, HB ? 16 : 4, HB ? 4 : 2};
        tbl[7] = '{5, 1, 3, 1, HB ? 63 : 15, -1, HB ? 9 : 3};
        tbl[8] = '{1023 - HB, 1, 1, 0, HB ? 3072 : 1023, HB ? 3072 : 1023, HB ? 3 : 1};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", all_outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", all_outs(), 32'd0);

        // Table-driven scans.
        foreach (tbl[i]) begin
            run_scan(tbl[i].c, tbl[i].r, tbl[i].p, tbl[i].mode, nb, nv, nr);
            check($sformatf("tbl%0d_beats", i), 32'(nb), 32'(tbl[i].exp_beats));
            check($sformatf("tbl%0d_row_last", i), 32'(nr), 32'(tbl[i].exp_rl));
            if (tbl[i].exp_valid >= 0)
                check($sformatf("tbl%0d_valid_cycles", i), 32'(nv), 32'(tbl[i].exp_valid));
        end

        // Abort at (2,1,0) of a 4x3x1 scan, together with a start request.
        @(posedge clk); #1;
        cfg_cols = 10'd4; cfg_rows = 9'd3; cfg_passes = 7'd1;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(out_valid && col == 10'(1 + HB * 1 + 1 - HB) && row == 9'd1) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_reached", 32'(cyc < 100), 32'd1);
        check("abort_pass", 32'(pass), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("abort_outs", all_outs(), 32'd0);
        @(negedge clk);
        check("abort_no_done", all_outs(), 32'd0);

        // Reset mid-scan takes effect without a clock edge.
        @(posedge clk); #1;
        cfg_cols = 10'd4; cfg_rows = 9'd3; cfg_passes = 7'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        check("pre_reset_col", 32'(col), 32'(5 % (4 + 2 * HB)));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", all_outs(), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset_needs_start", all_outs(), 32'd0);
        end
        run_scan(2, 2, 1, 0, nb, nv, nr);
        check("after_reset_beats", 32'(nb), 32'(HB ? 16 : 4));

        // Randomised geometry and handshake.
        for (int k = 0; k < 25; k++) begin
            c = int'($urandom_range(0, 6));
            r = int'($urandom_range(0, 5));
            p = int'($urandom_range(0, 3));
            run_scan(c, r, p, 1, nb, nv, nr);
            check("rand_beats", 32'(nb),
                  32'((c == 0 || r == 0 || p == 0) ? 0 : (c + 2 * HB) * (r + 2 * HB) * p));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
